adder_result_accumulator: RTL and testbench
===========================================

# adder_result_accumulator

Downstream consumer of the 4-bit adder stage. Accepts one 5-bit adder result per valid/ready handshake: carry_out in bit 4, sum in bits 3:0. Adds FRAME_LEN consecutive results into a wide accumulator, then presents the frame total with a sticky overflow flag on a valid/ready output port. Lets the datapath total many adder outputs without software intervention.

## Interface
- IN_WIDTH, default 5: width of one adder result ({carry_out, sum[3:0]}).
- ACC_WIDTH, default 10: accumulator and out_sum width; must be ≥ IN_WIDTH.
- FRAME_LEN, default 8: results per frame; must be ≥ 1.
- CNT_WIDTH, default $clog2(FRAME_LEN+1): sample counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid adder result.
- in_ready  out  1  block can take a result this cycle.
- in_data  in  IN_WIDTH  adder result, unsigned.
- clear  in  1  synchronous abort of the partial frame.
- out_valid  out  1  frame total is presented.
- out_ready  in  1  consumer takes the total this cycle.
- out_sum  out  ACC_WIDTH  frame total, modulo 2^ACC_WIDTH.
- out_overflow  out  1  the frame total wrapped at least once.
- out_count  out  CNT_WIDTH  results accepted in the current frame.

## Operation
- Two-state FSM: ACCUM and DONE.
- Reset, or rst high at any clock edge in either state:
  - state ← ACCUM;
  - acc, count and overflow ← 0;
  - out_valid = 0, in_ready = 1 after reset;
  - any in-flight frame is discarded.
- ACCUM:
  - in_ready = !clear; out_valid = 0.
  - Accept means in_valid && in_ready. On accept:
    - acc ← acc + zero-extended in_data, truncated to ACC_WIDTH;
    - overflow ← overflow | carry out of bit ACC_WIDTH-1;
    - count ← count + 1.
  - If the accept brings count to FRAME_LEN, next state is DONE; the registers hold the totals including that sample.
  - clear high: acc, count and overflow ← 0 and state stays ACCUM. No sample is accepted that cycle, because in_ready is low.
- DONE:
  - out_valid = 1, in_ready = 0.
  - out_sum, out_overflow and out_count (= FRAME_LEN) are stable until the output handshake.
  - clear is ignored.
  - On out_valid && out_ready: acc, count and overflow ← 0 and state ← ACCUM.
  - Without out_ready the state holds indefinitely, which backpressures the adder stage.
- out_sum = acc, out_overflow = overflow, out_count = count. All outputs come straight from registers, with no combinational path from inputs, except that in_ready depends on clear.
- Arithmetic is unsigned throughout. in_data is never sign-extended.

## Timing
- The accept at cycle N is visible in out_sum/out_count at cycle N+1.
- The FRAME_LEN-th accept at cycle N gives out_valid = 1 from cycle N+1.
- The output handshake at cycle M gives in_ready = 1 and out_sum = 0 at cycle M+1. That leaves one bubble cycle between frames, with no accept during the handshake cycle.
- Minimum frame period: FRAME_LEN + 1 cycles when in_valid and out_ready are held high.
- Simultaneous events:
  - rst overrides clear and both handshakes;
  - clear overrides an in-data accept in ACCUM.
- in_data is ignored whenever in_ready = 0.
- FRAME_LEN = 1: every accept moves straight to DONE.

## Test plan
- **Reset:** assert rst for 2 cycles while in_valid = 1 and in_data = 5'h1F. Required: no accept occurs; on release, out_sum = 0, out_count = 0, out_overflow = 0, out_valid = 0, in_ready = 1.
- **Full frame, defaults:** stream the 8 values 0, 1, 5, 9, 15, 16, 30, 31 with in_valid held high and out_ready = 0. Required:
  - out_valid rises exactly one cycle after the 8th accept;
  - out_sum = 107, out_overflow = 0, out_count = 8;
  - in_ready = 0 for 5 cycles while out_ready is held low, with all outputs stable.
- **Handshake and restart:** from the previous end state, pulse out_ready for 1 cycle. Required: the next cycle has out_valid = 0, in_ready = 1, out_sum = 0. A second frame of eight 5'd3 samples then gives out_sum = 24.
- **Overflow:** set ACC_WIDTH = 6 and FRAME_LEN = 4, and stream four 5'd31 samples. Required: out_sum = 124 mod 64 = 60, out_overflow = 1. The next frame, after the handshake, starts with out_overflow = 0.
- **Clear mid-frame:** after 3 accepts of 5'd7 (out_count = 3), assert clear for 1 cycle with in_valid = 1. Required:
  - in_ready = 0 that cycle and the sample is dropped;
  - next cycle out_sum = 0 and out_count = 0;
  - 8 further accepts of 5'd2 give out_sum = 16.
- **Gapped input and reset mid-frame:** drive in_valid with a random 50 % duty. Required: the total matches a reference model summing only handshaked samples. Asserting rst at out_count = 5 returns all outputs to their reset values the next cycle.

Source files
------------

// File: rtl/adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// adder_result_accumulator
//
// Totals FRAME_LEN consecutive 4-bit adder results ({carry_out, sum[3:0]})
// into a wide accumulator. It then presents the frame total, with a sticky
// overflow flag, on a valid/ready output port. While a finished total waits
// for its consumer, in_ready stays low, so the adder stage is backpressured.
//
// Parameters:
//   IN_WIDTH   width of one adder result (unsigned)
//   ACC_WIDTH  accumulator / out_sum width, >= IN_WIDTH
//   FRAME_LEN  results per frame, >= 1
//   CNT_WIDTH  sample counter width
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   in_valid      in_data holds a valid adder result
//   in_ready      block can take a result this cycle (low while clear is high)
//   in_data       adder result, unsigned
//   clear         synchronous abort of the partial frame (ignored in DONE)
//   out_valid     frame total is presented
//   out_ready     consumer takes the total this cycle
//   out_sum       frame total, modulo 2^ACC_WIDTH
//   out_overflow  the frame total wrapped at least once
//   out_count     results accepted in the current frame
// -----------------------------------------------------------------------------
module adder_result_accumulator #(
   parameter int IN_WIDTH  = 5,
   parameter int ACC_WIDTH = 10,
   parameter int FRAME_LEN = 8,
   parameter int CNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_overflow,
   output logic [CNT_WIDTH-1:0] out_count
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   // The frame is complete when an accept arrives with the count at this value.
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(FRAME_LEN - 1);

   state_t                 state;
   logic [ACC_WIDTH-1:0]   acc;
   logic [CNT_WIDTH-1:0]   count;
   logic                   overflow;

   logic                   accept;
   logic [ACC_WIDTH:0]     acc_next;   // extra MSB holds the carry out of acc

   // in_ready is the only output with a combinational path from an input.
   // clear suppresses it, so a clear cycle can never also accept a sample.
   assign in_ready = (state == ACCUM) && !clear;
   assign accept   = in_valid && in_ready;

   // The sized cast zero-extends in_data, because it is unsigned.
   assign acc_next = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);

   // NOTE: sequential state uses non-blocking assignments only. Every register
   //       then updates from values sampled at the same edge, whatever order
   //       the branches below take.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACCUM;
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (clear) begin
                  acc      <= '0;
                  count    <= '0;
                  overflow <= 1'b0;
               end else if (accept) begin
                  acc      <= acc_next[ACC_WIDTH-1:0];
                  overflow <= overflow | acc_next[ACC_WIDTH];
                  count    <= count + 1'b1;
                  if (count == LAST_COUNT) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               // The totals are held until the consumer takes them. clear is
               // ignored here.
               if (out_ready) begin
                  acc      <= '0;
                  count    <= '0;
                  overflow <= 1'b0;
                  state    <= ACCUM;
               end
            end
         endcase
      end
   end

   assign out_valid    = (state == DONE);
   assign out_sum      = acc;
   assign out_overflow = overflow;
   assign out_count    = count;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_result_accumulator
//
// Directed bench for adder_result_accumulator. Instance u_dut_def uses the
// default parameters. Instance u_dut_ovf uses ACC_WIDTH = 6 and FRAME_LEN = 4,
// so that the accumulator wraps. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_adder_result_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic       d_rst, d_in_valid, d_in_ready, d_clear, d_out_valid, d_out_ready;
   logic [4:0] d_in_data;
   logic [9:0] d_out_sum;
   logic       d_out_overflow;
   logic [3:0] d_out_count;

   // Small-accumulator instance
   logic       o_rst, o_in_valid, o_in_ready, o_clear, o_out_valid, o_out_ready;
   logic [4:0] o_in_data;
   logic [5:0] o_out_sum;
   logic       o_out_overflow;
   logic [2:0] o_out_count;

   int n_checks = 0;
   int n_fail   = 0;

   adder_result_accumulator u_dut_def (
      .clk          (clk),
      .rst          (d_rst),
      .in_valid     (d_in_valid),
      .in_ready     (d_in_ready),
      .in_data      (d_in_data),
      .clear        (d_clear),
      .out_valid    (d_out_valid),
      .out_ready    (d_out_ready),
      .out_sum      (d_out_sum),
      .out_overflow (d_out_overflow),
      .out_count    (d_out_count)
   );

   adder_result_accumulator #(
      .IN_WIDTH  (5),
      .ACC_WIDTH (6),
      .FRAME_LEN (4)
   ) u_dut_ovf (
      .clk          (clk),
      .rst          (o_rst),
      .in_valid     (o_in_valid),
      .in_ready     (o_in_ready),
      .in_data      (o_in_data),
      .clear        (o_clear),
      .out_valid    (o_out_valid),
      .out_ready    (o_out_ready),
      .out_sum      (o_out_sum),
      .out_overflow (o_out_overflow),
      .out_count    (o_out_count)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic d_handshake();
      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      step();
      d_out_ready = 1'b0;
   endtask

   logic [4:0] frame_vals [8] = '{5'd0, 5'd1, 5'd5, 5'd9, 5'd15, 5'd16, 5'd30, 5'd31};

   initial begin
      int unsigned model_sum;
      int          model_cnt;
      int          budget;
      logic        v;
      logic [4:0]  dat;

      // ---------------- Reset with a valid input pending ----------------
      d_rst = 1'b1; d_in_valid = 1'b1; d_in_data = 5'h1F; d_clear = 1'b0; d_out_ready = 1'b0;
      o_rst = 1'b1; o_in_valid = 1'b1; o_in_data = 5'h1F; o_clear = 1'b0; o_out_ready = 1'b0;
      step();
      step();
      d_rst = 1'b0; d_in_valid = 1'b0;
      o_rst = 1'b0; o_in_valid = 1'b0;
      #1;
      check("rst_sum",      d_out_sum,      0);
      check("rst_count",    d_out_count,    0);
      check("rst_overflow", d_out_overflow, 0);
      check("rst_valid",    d_out_valid,    0);
      check("rst_ready",    d_in_ready,     1);

      // ---------------- Full frame with default parameters ----------------
      for (int i = 0; i < 8; i++) begin
         d_in_valid = 1'b1;
         d_in_data  = frame_vals[i];
         step();
         check($sformatf("frame_count_%0d", i), d_out_count, i + 1);
         check($sformatf("frame_valid_%0d", i), d_out_valid, (i == 7) ? 1 : 0);
      end
      check("frame_sum",      d_out_sum,      107);
      check("frame_overflow", d_out_overflow, 0);
      // in_valid stays high with new data while the total waits
      d_in_data = 5'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold_ready_%0d", i), d_in_ready,  0);
         check($sformatf("hold_valid_%0d", i), d_out_valid, 1);
         check($sformatf("hold_sum_%0d", i),   d_out_sum,   107);
         check($sformatf("hold_count_%0d", i), d_out_count, 8);
      end

      // ---------------- Handshake and restart ----------------
      d_handshake();
      check("hs_valid", d_out_valid, 0);
      check("hs_ready", d_in_ready,  1);
      check("hs_sum",   d_out_sum,   0);
      check("hs_count", d_out_count, 0);
      for (int i = 0; i < 8; i++) begin
         d_in_valid = 1'b1;
         d_in_data  = 5'd3;
         step();
      end
      d_in_valid = 1'b0;
      check("frame2_sum",   d_out_sum,   24);
      check("frame2_valid", d_out_valid, 1);
      d_handshake();

      // ---------------- Clear in the middle of a frame ----------------
      for (int i = 0; i < 3; i++) begin
         d_in_valid = 1'b1;
         d_in_data  = 5'd7;
         step();
      end
      check("pre_clear_count", d_out_count, 3);
      check("pre_clear_sum",   d_out_sum,   21);
      d_clear = 1'b1;
      #1;
      check("clear_ready", d_in_ready, 0);
      step();
      d_clear = 1'b0;
      check("clear_sum",   d_out_sum,   0);
      check("clear_count", d_out_count, 0);
      for (int i = 0; i < 8; i++) begin
         d_in_valid = 1'b1;
         d_in_data  = 5'd2;
         step();
      end
      d_in_valid = 1'b0;
      check("post_clear_sum",   d_out_sum,   16);
      check("post_clear_valid", d_out_valid, 1);
      d_handshake();

      // ---------------- Gapped input against a reference sum ----------------
      model_sum = 0; model_cnt = 0; budget = 0;
      while (model_cnt < 8 && budget < 200) begin
         v   = 1'($urandom_range(0, 1));
         dat = 5'($urandom_range(0, 31));
         d_in_valid = v;
         d_in_data  = dat;
         step();
         if (v) begin
            model_sum += dat;
            model_cnt++;
         end
         budget++;
      end
      d_in_valid = 1'b0;
      check("gap_count",    d_out_count,    model_cnt);
      check("gap_sum",      d_out_sum,      model_sum % 1024);
      check("gap_overflow", d_out_overflow, (model_sum >= 1024) ? 1 : 0);
      check("gap_valid",    d_out_valid,    1);
      d_handshake();

      // ---------------- Reset in the middle of a frame ----------------
      model_sum = 0; model_cnt = 0; budget = 0;
      while (model_cnt < 5 && budget < 200) begin
         v   = 1'($urandom_range(0, 1));
         dat = 5'($urandom_range(0, 31));
         d_in_valid = v;
         d_in_data  = dat;
         step();
         if (v) begin
            model_sum += dat;
            model_cnt++;
         end
         budget++;
      end
      check("mid_count", d_out_count, 5);
      check("mid_sum",   d_out_sum,   model_sum);
      d_rst      = 1'b1;
      d_in_valid = 1'b1;
      d_in_data  = 5'd31;
      step();
      d_rst      = 1'b0;
      d_in_valid = 1'b0;
      check("mid_rst_sum",      d_out_sum,      0);
      check("mid_rst_count",    d_out_count,    0);
      check("mid_rst_overflow", d_out_overflow, 0);
      check("mid_rst_valid",    d_out_valid,    0);
      check("mid_rst_ready",    d_in_ready,     1);

      // ---------------- Overflow: ACC_WIDTH = 6, FRAME_LEN = 4 ----------------
      for (int i = 0; i < 4; i++) begin
         o_in_valid = 1'b1;
         o_in_data  = 5'd31;
         step();
         check($sformatf("ovf_valid_%0d", i), o_out_valid, (i == 3) ? 1 : 0);
      end
      o_in_valid = 1'b0;
      check("ovf_sum",      o_out_sum,      60);
      check("ovf_overflow", o_out_overflow, 1);
      check("ovf_count",    o_out_count,    4);
      o_out_ready = 1'b1;
      step();
      o_out_ready = 1'b0;
      check("ovf_hs_overflow", o_out_overflow, 0);
      check("ovf_hs_sum",      o_out_sum,      0);
      check("ovf_hs_ready",    o_in_ready,     1);
      for (int i = 0; i < 4; i++) begin
         o_in_valid = 1'b1;
         o_in_data  = 5'd1;
         step();
      end
      o_in_valid = 1'b0;
      check("ovf2_sum",      o_out_sum,      4);
      check("ovf2_overflow", o_out_overflow, 0);
      check("ovf2_valid",    o_out_valid,    1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
